// File: rtl/game_flow_controller.sv
// ----------------------------------------------------------------------------
// game_flow_controller
//
// Pong screen sequencer: MAIN menu, PLAYING, PAUSED and GAME_OVER. Debounces
// the raw pause/select buttons into single-cycle press pulses, then drives
// the menu GUI enables, the game-core run/reset controls and the latched
// winner flag. All outputs are registered.
//
// Optional build macro: IDLE_TIMEOUT_EN
//   defined   - PAUSED returns to MAIN after IDLE_TIMEOUT cycles without a press
//   undefined - PAUSED persists until a press
//
// Ports:
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   btn_pause_n      in   raw pause button, active low
//   btn_select_n     in   raw select button, active low
//   main_selection   in   [2:0] main menu choice (0 = start)
//   paused_selection in   [2:0] paused menu choice (0 continue, 1 restart, 2 main)
//   score_left       in   [3:0] left player score
//   score_right      in   [3:0] right player score
//   state            out  [2:0] MAIN=0, PLAYING=1, PAUSED=2, GAME_OVER=3
//   main_menu_en     out  high while in MAIN
//   paused_menu_en   out  high while in PAUSED
//   gameover_en      out  high while in GAME_OVER
//   game_run         out  high while in PLAYING
//   game_reset       out  one-cycle clear pulse for scores and positions
//   menu_reset_n     out  active-low one-cycle pulse clearing the menus
//   winner           out  0 = left, 1 = right; latched on GAME_OVER entry
// ----------------------------------------------------------------------------

// Button debouncer: 2-flop synchronizer, stability counter, falling-edge pulse.
module game_flow_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_n,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] cnt;

   // Synchronize, count consecutive differing samples, flip level and pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         cnt    <= CNT_ZERO;
         press  <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= sync2;
               cnt    <= CNT_ZERO;
               // Only a released-to-pressed flip (stable was 1) is a press.
               press  <= stable;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end else begin
            cnt <= CNT_ZERO;
         end
      end
   end
endmodule

module game_flow_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WIN_SCORE       = 5,
   parameter int IDLE_TIMEOUT    = 1800
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_pause_n,
   input  logic       btn_select_n,
   input  logic [2:0] main_selection,
   input  logic [2:0] paused_selection,
   input  logic [3:0] score_left,
   input  logic [3:0] score_right,
   output logic [2:0] state,
   output logic       main_menu_en,
   output logic       paused_menu_en,
   output logic       gameover_en,
   output logic       game_run,
   output logic       game_reset,
   output logic       menu_reset_n,
   output logic       winner
);
   typedef enum logic [2:0] {
      ST_MAIN      = 3'd0,
      ST_PLAYING   = 3'd1,
      ST_PAUSED    = 3'd2,
      ST_GAME_OVER = 3'd3
   } state_t;

   localparam logic [3:0] WIN_LEVEL = 4'(WIN_SCORE);

   state_t cur_state;
   state_t next_state;
   logic   sel_press;
   logic   pause_press;
   logic   after_reset;
   logic   left_win;
   logic   right_win;
   logic   idle_expired;
   logic   next_winner;
   logic   next_game_reset;
   logic   next_menu_reset_n;

   game_flow_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
      .clock (clock),
      .reset (reset),
      .btn_n (btn_select_n),
      .press (sel_press)
   );

   game_flow_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
      .clock (clock),
      .reset (reset),
      .btn_n (btn_pause_n),
      .press (pause_press)
   );

   assign left_win  = (score_left  >= WIN_LEVEL);
   assign right_win = (score_right >= WIN_LEVEL);
   assign state     = cur_state;

`ifdef IDLE_TIMEOUT_EN
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT);
   localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
   localparam logic [IW-1:0] IDLE_ZERO = IW'(0);

   logic [IW-1:0] idle_cnt;

   assign idle_expired = (idle_cnt == IDLE_LAST);

   // Idle counter: runs while PAUSED persists, clears on entry and on any press.
   always_ff @(posedge clock) begin
      if (reset) begin
         idle_cnt <= IDLE_ZERO;
      end else if ((cur_state == ST_PAUSED) && (next_state == ST_PAUSED) &&
                   !sel_press && !pause_press) begin
         idle_cnt <= idle_cnt + IDLE_ONE;
      end else begin
         idle_cnt <= IDLE_ZERO;
      end
   end
`else
   // Timeout compiled out; the parameter is non-negative so this stays low.
   assign idle_expired = (IDLE_TIMEOUT < 32'sd0);
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state <= ST_MAIN;
      end else begin
         cur_state <= next_state;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      next_state        = cur_state;
      next_winner       = winner;
      // Stretch the reset pulses one cycle past reset release.
      next_game_reset   = after_reset;
      next_menu_reset_n = ~after_reset;
      case (cur_state)
         ST_MAIN: begin
            if (sel_press && (main_selection == 3'd0)) begin
               next_state      = ST_PLAYING;
               next_game_reset = 1'b1;
            end else begin
               next_state = ST_MAIN;
            end
         end
         ST_PLAYING: begin
            if (left_win || right_win) begin
               next_state  = ST_GAME_OVER;
               next_winner = right_win && !left_win;
            end else if (pause_press) begin
               next_state        = ST_PAUSED;
               next_menu_reset_n = 1'b0;
            end else begin
               next_state = ST_PLAYING;
            end
         end
         ST_PAUSED: begin
            // A valid select beats a simultaneous pause press.
            if (sel_press && (paused_selection <= 3'd2)) begin
               case (paused_selection)
                  3'd0: next_state = ST_PLAYING;
                  3'd1: begin
                     next_state      = ST_PLAYING;
                     next_game_reset = 1'b1;
                  end
                  3'd2: begin
                     next_state        = ST_MAIN;
                     next_menu_reset_n = 1'b0;
                  end
                  default: next_state = ST_PAUSED;
               endcase
            end else if (pause_press) begin
               next_state = ST_PLAYING;
            end else if (idle_expired && !sel_press) begin
               next_state        = ST_MAIN;
               next_menu_reset_n = 1'b0;
            end else begin
               next_state = ST_PAUSED;
            end
         end
         ST_GAME_OVER: begin
            if (sel_press) begin
               next_state        = ST_MAIN;
               next_menu_reset_n = 1'b0;
            end else begin
               next_state = ST_GAME_OVER;
            end
         end
         default: begin
            next_state        = ST_MAIN;
            next_game_reset   = 1'b1;
            next_menu_reset_n = 1'b0;
         end
      endcase
   end

   // Output registers, updated together with the state change.
   always_ff @(posedge clock) begin
      if (reset) begin
         after_reset    <= 1'b1;
         winner         <= 1'b0;
         game_reset     <= 1'b1;
         menu_reset_n   <= 1'b0;
         main_menu_en   <= 1'b1;
         paused_menu_en <= 1'b0;
         gameover_en    <= 1'b0;
         game_run       <= 1'b0;
      end else begin
         after_reset    <= 1'b0;
         winner         <= next_winner;
         game_reset     <= next_game_reset;
         menu_reset_n   <= next_menu_reset_n;
         main_menu_en   <= (next_state == ST_MAIN);
         paused_menu_en <= (next_state == ST_PAUSED);
         gameover_en    <= (next_state == ST_GAME_OVER);
         game_run       <= (next_state == ST_PLAYING);
      end
   end
endmodule

// File: tb/tb_game_flow_controller.sv
// ----------------------------------------------------------------------------
// tb_game_flow_controller
//
// Directed bench for game_flow_controller with DEBOUNCE_CYCLES=4, WIN_SCORE=5.
// Outputs are sampled 1 time unit after each rising edge; a small monitor
// counts state transitions and reset pulses between checkpoints.
// ----------------------------------------------------------------------------
module tb_game_flow_controller;
   logic       clock = 1'b0;
   logic       reset;
   logic       btn_pause_n;
   logic       btn_select_n;
   logic [2:0] main_selection;
   logic [2:0] paused_selection;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic [2:0] state;
   logic       main_menu_en;
   logic       paused_menu_en;
   logic       gameover_en;
   logic       game_run;
   logic       game_reset;
   logic       menu_reset_n;
   logic       winner;

   int         checks = 0;
   int         errors = 0;
   int         trans;
   int         gr_cnt;
   int         mrn_cnt;
   logic       saw_paused;
   logic [2:0] prev_state;

   game_flow_controller #(
      .DEBOUNCE_CYCLES (4),
      .WIN_SCORE       (5)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .btn_pause_n      (btn_pause_n),
      .btn_select_n     (btn_select_n),
      .main_selection   (main_selection),
      .paused_selection (paused_selection),
      .score_left       (score_left),
      .score_right      (score_right),
      .state            (state),
      .main_menu_en     (main_menu_en),
      .paused_menu_en   (paused_menu_en),
      .gameover_en      (gameover_en),
      .game_run         (game_run),
      .game_reset       (game_reset),
      .menu_reset_n     (menu_reset_n),
      .winner           (winner)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (state !== prev_state) trans++;
      if (game_reset === 1'b1) gr_cnt++;
      if (menu_reset_n === 1'b0) mrn_cnt++;
      if (state === 3'd2) saw_paused = 1'b1;
      prev_state = state;
   endtask

   task automatic clear_mon();
      trans      = 0;
      gr_cnt     = 0;
      mrn_cnt    = 0;
      saw_paused = 1'b0;
      prev_state = state;
   endtask

   // Hold the chosen buttons low for 'hold' cycles, then release and settle.
   task automatic press(input logic sel, input logic pau, input int hold);
      btn_select_n = ~sel;
      btn_pause_n  = ~pau;
      repeat (hold) step();
      btn_select_n = 1'b1;
      btn_pause_n  = 1'b1;
      repeat (8) step();
   endtask

   initial begin
      reset            = 1'b1;
      btn_pause_n      = 1'b1;
      btn_select_n     = 1'b1;
      main_selection   = 3'd0;
      paused_selection = 3'd0;
      score_left       = 4'd0;
      score_right      = 4'd0;
      prev_state       = 3'd0;
      trans = 0; gr_cnt = 0; mrn_cnt = 0; saw_paused = 1'b0;

      // Reset state
      repeat (3) step();
      check_value("rst_state", state, 3'd0);
      check_value("rst_main_en", main_menu_en, 1'b1);
      check_value("rst_paused_en", paused_menu_en, 1'b0);
      check_value("rst_gameover_en", gameover_en, 1'b0);
      check_value("rst_game_run", game_run, 1'b0);
      check_value("rst_game_reset", game_reset, 1'b1);
      check_value("rst_menu_reset_n", menu_reset_n, 1'b0);
      check_value("rst_winner", winner, 1'b0);
      reset = 1'b0;
      step();
      check_value("post_rst_game_reset", game_reset, 1'b1);
      check_value("post_rst_menu_reset_n", menu_reset_n, 1'b0);
      step();
      check_value("post_rst2_game_reset", game_reset, 1'b0);
      check_value("post_rst2_menu_reset_n", menu_reset_n, 1'b1);

      // MAIN ignores non-zero selection and pause
      clear_mon();
      main_selection = 3'd3;
      press(1'b1, 1'b0, 8);
      press(1'b0, 1'b1, 8);
      check_value("main_ignore_state", state, 3'd0);
      check_value("main_ignore_trans", trans, 0);

      // Start game: 10-cycle select hold, exact latency
      clear_mon();
      main_selection = 3'd0;
      btn_select_n = 1'b0;
      repeat (6) step();
      check_value("start_before", state, 3'd0);
      step();
      check_value("start_state", state, 3'd1);
      check_value("start_game_reset", game_reset, 1'b1);
      step();
      check_value("start_game_reset_end", game_reset, 1'b0);
      repeat (2) step();
      btn_select_n = 1'b1;
      repeat (8) step();
      check_value("start_trans", trans, 1);
      check_value("start_gr_cnt", gr_cnt, 1);
      check_value("start_game_run", game_run, 1'b1);
      check_value("start_main_en", main_menu_en, 1'b0);

      // Glitch on pause, then long hold
      clear_mon();
      press(1'b0, 1'b1, 2);
      check_value("glitch_state", state, 3'd1);
      check_value("glitch_trans", trans, 0);
      clear_mon();
      press(1'b0, 1'b1, 16);
      check_value("pause_state", state, 3'd2);
      check_value("pause_en", paused_menu_en, 1'b1);
      check_value("pause_game_run", game_run, 1'b0);
      check_value("pause_mrn_cnt", mrn_cnt, 1);
      check_value("pause_trans", trans, 1);
      check_value("pause_gr_cnt", gr_cnt, 0);

      // PAUSED selections
      clear_mon();
      paused_selection = 3'd1;
      press(1'b1, 1'b0, 8);
      check_value("restart_state", state, 3'd1);
      check_value("restart_gr_cnt", gr_cnt, 1);
      check_value("restart_trans", trans, 1);
      press(1'b0, 1'b1, 8);
      clear_mon();
      paused_selection = 3'd2;
      press(1'b1, 1'b0, 8);
      check_value("tomain_state", state, 3'd0);
      check_value("tomain_mrn_cnt", mrn_cnt, 1);
      check_value("tomain_main_en", main_menu_en, 1'b1);
      press(1'b1, 1'b0, 8);
      press(1'b0, 1'b1, 8);
      check_value("repause_state", state, 3'd2);
      clear_mon();
      paused_selection = 3'd5;
      press(1'b1, 1'b0, 8);
      check_value("sel5_state", state, 3'd2);
      check_value("sel5_trans", trans, 0);
      clear_mon();
      press(1'b0, 1'b1, 8);
      check_value("resume_state", state, 3'd1);
      check_value("resume_gr_cnt", gr_cnt, 0);
      check_value("resume_trans", trans, 1);

      // Win beats a pause press in the same cycle
      clear_mon();
      btn_pause_n = 1'b0;
      repeat (6) step();
      score_right = 4'd5;
      score_left  = 4'd3;
      step();
      check_value("win_state", state, 3'd3);
      check_value("win_winner", winner, 1'b1);
      check_value("win_gameover_en", gameover_en, 1'b1);
      btn_pause_n = 1'b1;
      repeat (8) step();
      check_value("win_no_paused", saw_paused, 1'b0);
      clear_mon();
      press(1'b0, 1'b1, 8);
      check_value("gameover_pause_state", state, 3'd3);
      check_value("gameover_pause_trans", trans, 0);
      score_left  = 4'd0;
      score_right = 4'd0;
      press(1'b1, 1'b0, 8);
      check_value("gameover_exit_state", state, 3'd0);
      check_value("winner_hold", winner, 1'b1);
      press(1'b1, 1'b0, 8);
      score_left  = 4'd5;
      score_right = 4'd5;
      step();
      check_value("tie_state", state, 3'd3);
      check_value("tie_winner", winner, 1'b0);
      score_left  = 4'd0;
      score_right = 4'd0;

      // Simultaneous select and pause in PAUSED
      press(1'b1, 1'b0, 8);
      press(1'b1, 1'b0, 8);
      press(1'b0, 1'b1, 8);
      check_value("simul_pre_state", state, 3'd2);
      clear_mon();
      paused_selection = 3'd2;
      press(1'b1, 1'b1, 8);
      check_value("simul_state", state, 3'd0);
      check_value("simul_trans", trans, 1);

      // Reset mid-debounce in PAUSED, then a too-short press
      press(1'b1, 1'b0, 8);
      press(1'b0, 1'b1, 8);
      check_value("mid_pre_state", state, 3'd2);
      btn_pause_n = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      btn_pause_n = 1'b1;
      repeat (2) step();
      check_value("mid_rst_state", state, 3'd0);
      check_value("mid_rst_main_en", main_menu_en, 1'b1);
      check_value("mid_rst_game_run", game_run, 1'b0);
      reset = 1'b0;
      repeat (4) step();
      clear_mon();
      main_selection = 3'd0;
      press(1'b1, 1'b0, 3);
      check_value("short_state", state, 3'd0);
      check_value("short_trans", trans, 0);
      check_value("short_gr_cnt", gr_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
